lpif_asym_link_sync: RTL and testbench
======================================

Name: lpif_asym_link_sync

Overview:
- Parametrised link-sync controller for LPIF-over-AIB asymmetric transceivers.
- Replaces the fixed-config auto-sync used by per-ratio TX/RX tops.
- Handles any channel count and full/half/quarter rate selected at runtime.
- Sequences TX/RX online with programmable delays, generates marker/strobe userbits per rate, and monitors received strobes per channel for lock/loss.

Parameters:
NUM_CH, 2, number of PHY channels (1..8)
MARKER_WIDTH, 4, marker userbits per channel word group
STB_PERIOD, 8, word groups between persistent strobes (>=1)
LOCK_CNT, 4, consecutive on-time strobes required for rx lock (>=1)
PERSISTENT_MARKER, 1, 1: markers continue after sync; 0: markers only during SYNC
PERSISTENT_STROBE, 1, 1: strobes continue after sync; 0: strobes only during SYNC

Ports:
clk_wr  in  1  link clock
rst_wr_n  in  1  async active-low reset
tx_online  in  1  TX channel-alignment done
rx_online  in  1  RX channel-alignment done
rate_mode  in  2  0 full, 1 half, 2 quarter, 3 reserved (treated as quarter)
m_gen2_mode  in  1  0 forces full rate
delay_x_value  in  16  rx_online delay cycles
delay_y_value  in  16  tx_online to SYNC delay
delay_z_value  in  16  SYNC length before ONLINE
tx_mrk_userbit  in  MARKER_WIDTH  user marker bits (passed when not auto)
tx_stb_userbit  in  1  user strobe bit
rx_stb_in  in  NUM_CH  received strobe bit per channel
tx_auto_mrk_userbit  out  MARKER_WIDTH  marker bits to concat
tx_auto_stb_userbit  out  1  strobe bit to concat
tx_online_delay  out  1  TX data path enable
rx_online_delay  out  1  RX data path enable
rx_lock  out  NUM_CH  per-channel strobe lock
rx_stb_err  out  NUM_CH  sticky strobe-miss after lock
sync_state  out  3  TX FSM state (debug)

Behaviour:
- All outputs reset to 0; sync_state = IDLE (0).
- Effective ratio R = 1 if !m_gen2_mode, else 1/2/4 per rate_mode. Sampled only in IDLE; changes outside IDLE are ignored until the next IDLE.
- Beat counter b counts 0..R-1, wraps, runs while FSM is not IDLE.
- Group counter g increments when b = R-1 and wraps at STB_PERIOD-1.
- TX FSM states:
  - IDLE(0): enter DLY_Y when tx_online=1; load count = delay_y_value.
  - DLY_Y(1): decrement count. At 0, enter SYNC, load delay_z_value, and clear b and g.
  - SYNC(2): decrement count. At 0, enter ONLINE.
  - ONLINE(3): tx_online_delay=1 registered (asserts the cycle after entry).
  - Any state -> IDLE on tx_online=0 in the same cycle. Outputs clear the next cycle.
  - A delay of 0 means one cycle in that state.
- Marker generation:
  - During SYNC, or ONLINE with PERSISTENT_MARKER: tx_auto_mrk_userbit[MARKER_WIDTH-1] = (b = R-1); other bits 0.
  - Otherwise: tx_mrk_userbit passes through.
- Strobe generation:
  - During SYNC, or ONLINE with PERSISTENT_STROBE: tx_auto_stb_userbit = (b = 0 and g = 0).
  - Otherwise: tx_stb_userbit passes through.
  - Outputs are registered, one-cycle latency from b/g.
- RX online: on rx_online rising, counter loads delay_x_value. rx_online_delay=1 when the counter reaches 0. rx_online=0 clears it and the counter immediately.
- Per-channel strobe monitor, active when rx_online_delay=1:
  - Interval counter expects the next strobe exactly STB_PERIOD*R cycles after the previous one.
  - On-time strobe increments hit count, saturating at LOCK_CNT; rx_lock=1 at LOCK_CNT.
  - Early or missing strobe (counter passes expected) resets hit count and clears rx_lock. If rx_lock was 1, rx_stb_err sets; it is sticky until rx_online falls or reset.
  - The first strobe after enable only starts the interval; it is not counted.
  - A strobe coincident with the expected edge counts as on time.
- Reset mid-operation: all state returns to IDLE asynchronously; no partial outputs.

Decomposition:
- Package lpif_sync_pkg holds:
  - sync_state_e enum: IDLE, DLY_Y, SYNC, ONLINE.
  - rate_e enum and ratio function rate_to_ratio(m_gen2_mode, rate_mode).
  - Constant CNT_W=16.
- Sub-module lpif_stb_monitor: one per channel via generate. Ports clk_wr, rst_wr_n, enable, ratio, rx_stb; outputs lock and err.

Test Plan:
1. Gen2, quarter, delay_y=3, delay_z=5, tx_online rises at T:
   - DLY_Y for 4 cycles, SYNC for 6 cycles.
   - tx_online_delay=1 at T+11.
   - mrk[3] pulses every 4th cycle; stb pulses every 32 cycles from SYNC entry.
2. m_gen2_mode=0, rate_mode=2: R=1, so mrk[3] is constant 1 and strobe is every 8 cycles.
3. PERSISTENT_STROBE=0, ONLINE with tx_stb_userbit=1: output strobe=1 (pass-through); during SYNC it follows the auto pattern.
4. NUM_CH=2, half rate, strobes every 16 cycles on both channels: rx_lock=11 after the 5th strobe. Drop one ch1 strobe: rx_lock=01, rx_stb_err=10 (sticky).
5. tx_online deasserted during SYNC: sync_state=IDLE next cycle; markers revert to tx_mrk_userbit. Re-assert: the full delay sequence restarts.
6. rst_wr_n asserted in ONLINE with lock held: all outputs 0 asynchronously. After release with rx_online=1 and delay_x=2: rx_online_delay=1 after 3 cycles.

Source files
------------

// File: rtl/lpif_sync_pkg.sv
// Shared types and helpers for the LPIF-over-AIB asymmetric link-sync controller.
// The TX state encoding is also visible on the sync_state debug output.
package lpif_sync_pkg;

  localparam int CNT_W   = 16;
  localparam int RATIO_W = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DLY_Y  = 3'd1,
    SYNC   = 3'd2,
    ONLINE = 3'd3
  } sync_state_e;

  typedef enum logic [1:0] {
    RATE_FULL    = 2'd0,
    RATE_HALF    = 2'd1,
    RATE_QUARTER = 2'd2,
    RATE_RSVD    = 2'd3
  } rate_e;

  // Words per channel beat group; the reserved code behaves as quarter rate.
  function automatic logic [RATIO_W-1:0] rate_to_ratio(input logic       m_gen2_mode,
                                                       input logic [1:0] rate_mode);
    logic [RATIO_W-1:0] r;
    if (!m_gen2_mode) begin
      r = 3'd1;
    end else begin
      case (rate_e'(rate_mode))
        RATE_FULL: r = 3'd1;
        RATE_HALF: r = 3'd2;
        default:   r = 3'd4;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/lpif_stb_monitor.sv
// Per-channel received-strobe monitor: checks the strobe interval, declares lock
// after LOCK_CNT on-time strobes and flags a sticky error on loss after lock.
module lpif_stb_monitor
  import lpif_sync_pkg::*;
#(
  parameter int STB_PERIOD = 8,
  parameter int LOCK_CNT   = 4
) (
  input  logic               clk_wr,
  input  logic               rst_wr_n,
  input  logic               enable,
  input  logic [RATIO_W-1:0] ratio,
  input  logic               rx_stb,
  output logic               lock,
  output logic               err
);

  localparam int HIT_W = $clog2(LOCK_CNT + 1);

  logic [CNT_W-1:0] expected;
  logic [CNT_W-1:0] int_cnt_q, int_cnt_d;
  logic [HIT_W-1:0] hit_q, hit_d;
  logic             started_q, started_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d;

  assign expected = CNT_W'(STB_PERIOD) * CNT_W'(ratio);

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latch).
    int_cnt_d = int_cnt_q;
    hit_d     = hit_q;
    started_d = started_q;
    lock_d    = lock_q;
    err_d     = err_q;
    if (!enable) begin
      int_cnt_d = '0;
      hit_d     = '0;
      started_d = 1'b0;
      lock_d    = 1'b0;
      err_d     = 1'b0;
    end else if (!started_q) begin
      if (rx_stb) begin
        started_d = 1'b1;
        int_cnt_d = CNT_W'(1);
      end
    end else if (rx_stb && (int_cnt_q == expected)) begin
      int_cnt_d = CNT_W'(1);
      if (hit_q != HIT_W'(LOCK_CNT)) hit_d = hit_q + HIT_W'(1);
      lock_d = (hit_d == HIT_W'(LOCK_CNT));
    end else if (rx_stb || (int_cnt_q >= expected)) begin
      // An early strobe restarts the interval; a missing one waits for the next strobe to restart.
      hit_d     = '0;
      lock_d    = 1'b0;
      err_d     = err_q | lock_q;
      started_d = rx_stb;
      int_cnt_d = rx_stb ? CNT_W'(1) : '0;
    end else begin
      int_cnt_d = int_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      int_cnt_q <= '0;
      hit_q     <= '0;
      started_q <= 1'b0;
      lock_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      int_cnt_q <= int_cnt_d;
      hit_q     <= hit_d;
      started_q <= started_d;
      lock_q    <= lock_d;
      err_q     <= err_d;
    end
  end

  assign lock = lock_q;
  assign err  = err_q;

endmodule

// File: rtl/lpif_asym_link_sync.sv
// Runtime-configurable link-sync controller: sequences TX/RX online, generates
// marker/strobe userbits for the selected rate and monitors received strobes.
module lpif_asym_link_sync
  import lpif_sync_pkg::*;
#(
  parameter int NUM_CH            = 2,
  parameter int MARKER_WIDTH      = 4,
  parameter int STB_PERIOD        = 8,
  parameter int LOCK_CNT          = 4,
  parameter int PERSISTENT_MARKER = 1,
  parameter int PERSISTENT_STROBE = 1
) (
  input  logic                    clk_wr,
  input  logic                    rst_wr_n,
  input  logic                    tx_online,
  input  logic                    rx_online,
  input  logic [1:0]              rate_mode,
  input  logic                    m_gen2_mode,
  input  logic [15:0]             delay_x_value,
  input  logic [15:0]             delay_y_value,
  input  logic [15:0]             delay_z_value,
  input  logic [MARKER_WIDTH-1:0] tx_mrk_userbit,
  input  logic                    tx_stb_userbit,
  input  logic [NUM_CH-1:0]       rx_stb_in,
  output logic [MARKER_WIDTH-1:0] tx_auto_mrk_userbit,
  output logic                    tx_auto_stb_userbit,
  output logic                    tx_online_delay,
  output logic                    rx_online_delay,
  output logic [NUM_CH-1:0]       rx_lock,
  output logic [NUM_CH-1:0]       rx_stb_err,
  output logic [2:0]              sync_state
);

  sync_state_e              state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [RATIO_W-1:0]       ratio_q;
  logic [1:0]               beat_q;
  logic [CNT_W-1:0]         group_q;
  logic [MARKER_WIDTH-1:0]  mrk_q;
  logic                     stb_q;
  logic                     tx_od_q;

  logic                     last_beat;
  logic                     last_group;
  logic                     enter_sync;
  logic                     auto_mrk_en;
  logic                     auto_stb_en;
  logic [MARKER_WIDTH-1:0]  auto_mrk;

  assign last_beat   = ({1'b0, beat_q} == (ratio_q - RATIO_W'(1)));
  assign last_group  = (group_q == CNT_W'(STB_PERIOD - 1));
  assign enter_sync  = tx_online && (state_q == DLY_Y) && (cnt_q == '0);
  // Gating with tx_online makes the userbits revert on the same edge the FSM drops to IDLE.
  assign auto_mrk_en = tx_online && ((state_q == SYNC) ||
                       ((state_q == ONLINE) && (PERSISTENT_MARKER != 0)));
  assign auto_stb_en = tx_online && ((state_q == SYNC) ||
                       ((state_q == ONLINE) && (PERSISTENT_STROBE != 0)));

  always_comb begin
    auto_mrk                   = '0;
    auto_mrk[MARKER_WIDTH-1]   = last_beat;
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ratio_q <= RATIO_W'(1);
      beat_q  <= '0;
      group_q <= '0;
      mrk_q   <= '0;
      stb_q   <= 1'b0;
      tx_od_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
      if (!tx_online) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= DLY_Y;
            cnt_q   <= delay_y_value;
          end
          DLY_Y: begin
            if (cnt_q == '0) begin
              state_q <= SYNC;
              cnt_q   <= delay_z_value;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          SYNC: begin
            if (cnt_q == '0) state_q <= ONLINE;
            else             cnt_q   <= cnt_q - CNT_W'(1);
          end
          ONLINE:  state_q <= ONLINE;
          default: state_q <= IDLE;
        endcase
      end

      // The rate is frozen for the whole sequence once the FSM leaves IDLE.
      if (state_q == IDLE) ratio_q <= rate_to_ratio(m_gen2_mode, rate_mode);

      if ((state_q == IDLE) || enter_sync) begin
        beat_q  <= '0;
        group_q <= '0;
      end else begin
        beat_q <= last_beat ? 2'd0 : beat_q + 2'd1;
        if (last_beat) group_q <= last_group ? '0 : group_q + CNT_W'(1);
      end

      mrk_q   <= auto_mrk_en ? auto_mrk : tx_mrk_userbit;
      stb_q   <= auto_stb_en ? ((beat_q == 2'd0) && (group_q == '0)) : tx_stb_userbit;
      tx_od_q <= tx_online && (state_q == ONLINE);
    end
  end

  logic             rx_online_q;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic             rx_od_q, rx_od_d;

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    rx_od_d  = rx_od_q;
    if (!rx_online) begin
      rx_cnt_d = '0;
      rx_od_d  = 1'b0;
    end else if (!rx_online_q) begin
      rx_cnt_d = delay_x_value;
      rx_od_d  = (delay_x_value == '0);
    end else if (!rx_od_q) begin
      if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - CNT_W'(1);
      rx_od_d = (rx_cnt_q <= CNT_W'(1));
    end
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      rx_online_q <= 1'b0;
      rx_cnt_q    <= '0;
      rx_od_q     <= 1'b0;
    end else begin
      rx_online_q <= rx_online;
      rx_cnt_q    <= rx_cnt_d;
      rx_od_q     <= rx_od_d;
    end
  end

  logic mon_en;
  assign mon_en = rx_od_q && rx_online;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_mon
    lpif_stb_monitor #(
      .STB_PERIOD (STB_PERIOD),
      .LOCK_CNT   (LOCK_CNT)
    ) u_mon (
      .clk_wr   (clk_wr),
      .rst_wr_n (rst_wr_n),
      .enable   (mon_en),
      .ratio    (ratio_q),
      .rx_stb   (rx_stb_in[ch]),
      .lock     (rx_lock[ch]),
      .err      (rx_stb_err[ch])
    );
  end

  assign tx_auto_mrk_userbit = mrk_q;
  assign tx_auto_stb_userbit = stb_q;
  assign tx_online_delay     = tx_od_q;
  assign rx_online_delay     = rx_od_q;
  assign sync_state          = state_q;

endmodule

// File: tb/tb_lpif_asym_link_sync.sv
// Scoreboard bench for lpif_asym_link_sync: stimulus queues cycle-tagged expectations,
// a negedge monitor compares them against the DUT outputs.
module tb_lpif_asym_link_sync;

  logic        clk_wr = 1'b0;
  logic        rst_wr_n;
  logic        tx_online, rx_online;
  logic [1:0]  rate_mode;
  logic        m_gen2_mode;
  logic [15:0] delay_x_value, delay_y_value, delay_z_value;
  logic [3:0]  tx_mrk_userbit;
  logic        tx_stb_userbit;
  logic [1:0]  rx_stb_in;

  logic [3:0]  mrk, np_mrk;
  logic        stb, np_stb;
  logic        txod, np_txod, rxod, np_rxod;
  logic [1:0]  lock, np_lock, err, np_err;
  logic [2:0]  state, np_state;

  always #5 clk_wr = ~clk_wr;

  lpif_asym_link_sync #(
    .NUM_CH(2), .MARKER_WIDTH(4), .STB_PERIOD(8), .LOCK_CNT(4),
    .PERSISTENT_MARKER(1), .PERSISTENT_STROBE(1)
  ) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .tx_online(tx_online), .rx_online(rx_online),
    .rate_mode(rate_mode), .m_gen2_mode(m_gen2_mode), .delay_x_value(delay_x_value),
    .delay_y_value(delay_y_value), .delay_z_value(delay_z_value),
    .tx_mrk_userbit(tx_mrk_userbit), .tx_stb_userbit(tx_stb_userbit), .rx_stb_in(rx_stb_in),
    .tx_auto_mrk_userbit(mrk), .tx_auto_stb_userbit(stb), .tx_online_delay(txod),
    .rx_online_delay(rxod), .rx_lock(lock), .rx_stb_err(err), .sync_state(state)
  );

  lpif_asym_link_sync #(
    .NUM_CH(2), .MARKER_WIDTH(4), .STB_PERIOD(8), .LOCK_CNT(4),
    .PERSISTENT_MARKER(0), .PERSISTENT_STROBE(0)
  ) dut_np (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .tx_online(tx_online), .rx_online(rx_online),
    .rate_mode(rate_mode), .m_gen2_mode(m_gen2_mode), .delay_x_value(delay_x_value),
    .delay_y_value(delay_y_value), .delay_z_value(delay_z_value),
    .tx_mrk_userbit(tx_mrk_userbit), .tx_stb_userbit(tx_stb_userbit), .rx_stb_in(rx_stb_in),
    .tx_auto_mrk_userbit(np_mrk), .tx_auto_stb_userbit(np_stb), .tx_online_delay(np_txod),
    .rx_online_delay(np_rxod), .rx_lock(np_lock), .rx_stb_err(np_err), .sync_state(np_state)
  );

  typedef enum int {S_STATE, S_TXOD, S_MRK, S_STB, S_RXOD, S_LOCK, S_ERR, S_NP_MRK, S_NP_STB} sig_e;

  typedef struct {
    int unsigned cyc;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          finishing = 1'b0;
  logic [31:0] mon_act;

  always @(posedge clk_wr) cyc <= cyc + 1;

  function automatic logic [31:0] dut_val(input sig_e s);
    case (s)
      S_STATE:  return 32'(state);
      S_TXOD:   return 32'(txod);
      S_MRK:    return 32'(mrk);
      S_STB:    return 32'(stb);
      S_RXOD:   return 32'(rxod);
      S_LOCK:   return 32'(lock);
      S_ERR:    return 32'(err);
      S_NP_MRK: return 32'(np_mrk);
      default:  return 32'(np_stb);
    endcase
  endfunction

  task automatic expect_at(input int unsigned c, input sig_e s, input logic [31:0] v,
                           input string n);
    exp_t e;
    e.cyc = c; e.sig = s; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  // Monitor: compares every expectation due this cycle; anything overdue or left at the end fails.
  always @(negedge clk_wr) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (finishing || sb[i].cyc <= cyc) begin
        checks++;
        mon_act = dut_val(sb[i].sig);
        if (sb[i].cyc != cyc) begin
          errors++;
          $display("FAIL %s expired: due cyc %0d, now %0d", sb[i].name, sb[i].cyc, cyc);
        end else if (mon_act !== sb[i].val) begin
          errors++;
          $display("FAIL %s cyc %0d: got %0h expected %0h", sb[i].name, cyc, mon_act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_wr);
    #1;
  endtask

  task automatic expect_all_zero(input int unsigned c, input string tag);
    expect_at(c, S_STATE, 0, {tag, "_state"});
    expect_at(c, S_TXOD,  0, {tag, "_txod"});
    expect_at(c, S_MRK,   0, {tag, "_mrk"});
    expect_at(c, S_STB,   0, {tag, "_stb"});
    expect_at(c, S_RXOD,  0, {tag, "_rxod"});
    expect_at(c, S_LOCK,  0, {tag, "_lock"});
    expect_at(c, S_ERR,   0, {tag, "_err"});
  endtask

  int unsigned t0, t1, t2, r, c;
  int          rel;
  logic        strobe_now;

  initial begin
    rst_wr_n       = 1'b0;
    tx_online      = 1'b0;
    rx_online      = 1'b0;
    rate_mode      = 2'd2;
    m_gen2_mode    = 1'b1;
    delay_x_value  = 16'd0;
    delay_y_value  = 16'd0;
    delay_z_value  = 16'd0;
    tx_mrk_userbit = 4'h5;
    tx_stb_userbit = 1'b0;
    rx_stb_in      = 2'b00;

    tick(2);
    expect_all_zero(cyc, "reset");
    tick(1);
    rst_wr_n = 1'b1;
    tick(2);

    // Gen2 quarter rate, y=3, z=5; user strobe high to expose pass-through vs auto.
    delay_y_value  = 16'd3;
    delay_z_value  = 16'd5;
    tx_stb_userbit = 1'b1;
    tx_online      = 1'b1;
    t0 = cyc + 1;
    expect_at(t0 + 3,  S_STATE, 1, "q_dly_y_last");
    expect_at(t0 + 4,  S_STATE, 2, "q_sync_first");
    expect_at(t0 + 9,  S_STATE, 2, "q_sync_last");
    expect_at(t0 + 10, S_STATE, 3, "q_online");
    expect_at(t0 + 10, S_TXOD,  0, "q_txod_early");
    expect_at(t0 + 11, S_TXOD,  1, "q_txod");
    expect_at(t0 + 2,  S_MRK,   5, "q_mrk_pass");
    expect_at(t0 + 2,  S_STB,   1, "q_stb_pass");
    expect_at(t0 + 4,  S_MRK,   5, "q_mrk_pass_last");
    expect_at(t0 + 5,  S_MRK,   0, "q_mrk_b0");
    expect_at(t0 + 5,  S_STB,   1, "q_stb_first");
    expect_at(t0 + 6,  S_STB,   0, "q_stb_auto_low");
    expect_at(t0 + 7,  S_MRK,   0, "q_mrk_b2");
    expect_at(t0 + 8,  S_MRK,   8, "q_mrk_b3");
    expect_at(t0 + 12, S_MRK,   8, "q_mrk_online");
    expect_at(t0 + 36, S_STB,   0, "q_stb_gap");
    expect_at(t0 + 37, S_STB,   1, "q_stb_period");
    expect_at(t0 + 5,  S_NP_STB, 1, "np_stb_sync_auto");
    expect_at(t0 + 8,  S_NP_MRK, 8, "np_mrk_sync_auto");
    expect_at(t0 + 12, S_NP_MRK, 5, "np_mrk_online_pass");
    expect_at(t0 + 36, S_NP_STB, 1, "np_stb_online_pass");
    tick(40);

    // Gen1 forces R=1 regardless of rate_mode; abort in SYNC and restart.
    tx_online     = 1'b0;
    m_gen2_mode   = 1'b0;
    rate_mode     = 2'd2;
    delay_y_value = 16'd1;
    delay_z_value = 16'd20;
    expect_at(cyc + 1, S_STATE, 0, "drop_online_state");
    expect_at(cyc + 1, S_TXOD,  0, "drop_online_txod");
    expect_at(cyc + 1, S_MRK,   5, "drop_online_mrk");
    tick(1);
    tx_online = 1'b1;
    t1 = cyc + 1;
    expect_at(t1 + 1,  S_STATE, 1, "g1_dly_y");
    expect_at(t1 + 2,  S_STATE, 2, "g1_sync");
    expect_at(t1 + 3,  S_MRK,   8, "g1_mrk_a");
    expect_at(t1 + 4,  S_MRK,   8, "g1_mrk_b");
    expect_at(t1 + 3,  S_STB,   1, "g1_stb_first");
    expect_at(t1 + 4,  S_STB,   0, "g1_stb_low");
    expect_at(t1 + 10, S_STB,   0, "g1_stb_gap");
    expect_at(t1 + 11, S_STB,   1, "g1_stb_period");
    tick(5);
    m_gen2_mode = 1'b1;
    rate_mode   = 2'd1;
    expect_at(t1 + 8, S_MRK, 8, "rate_change_ignored_a");
    expect_at(t1 + 9, S_MRK, 8, "rate_change_ignored_b");
    tick(8);
    tx_online = 1'b0;
    expect_at(t1 + 13, S_STATE, 0, "abort_sync_state");
    expect_at(t1 + 13, S_MRK,   5, "abort_sync_mrk");
    expect_at(t1 + 13, S_STB,   1, "abort_sync_stb");
    tick(1);
    delay_y_value = 16'd3;
    tx_online     = 1'b1;
    t2 = cyc + 1;
    expect_at(t2 + 3, S_STATE, 1, "restart_dly_y");
    expect_at(t2 + 4, S_STATE, 2, "restart_sync");
    expect_at(t2 + 5, S_STB,   1, "restart_stb");
    expect_at(t2 + 5, S_MRK,   0, "half_mrk_b0");
    expect_at(t2 + 6, S_MRK,   8, "half_mrk_b1");
    expect_at(t2 + 6, S_STB,   0, "restart_stb_low");
    tick(8);
    tx_online = 1'b0;
    tick(2);

    // Half rate RX lock on both channels, then one missing ch1 strobe; TX goes ONLINE alongside.
    delay_x_value = 16'd2;
    delay_y_value = 16'd0;
    delay_z_value = 16'd0;
    rx_online     = 1'b1;
    tx_online     = 1'b1;
    r = cyc;
    expect_at(r + 2,   S_RXOD,  0, "rx_dly_wait");
    expect_at(r + 3,   S_RXOD,  1, "rx_dly_done");
    expect_at(r + 3,   S_STATE, 3, "zero_delay_online");
    expect_at(r + 4,   S_TXOD,  1, "zero_delay_txod");
    expect_at(r + 68,  S_LOCK,  0, "lock_before_5th");
    expect_at(r + 69,  S_LOCK,  3, "lock_both");
    expect_at(r + 84,  S_LOCK,  3, "lock_held");
    expect_at(r + 84,  S_ERR,   0, "err_clear");
    expect_at(r + 85,  S_LOCK,  1, "lock_lost_ch1");
    expect_at(r + 85,  S_ERR,   2, "err_ch1");
    expect_at(r + 101, S_LOCK,  1, "ch1_restart_unlocked");
    expect_at(r + 102, S_ERR,   2, "err_sticky");
    expect_at(r + 104, S_STATE, 3, "pre_reset_online");
    expect_at(r + 104, S_LOCK,  1, "pre_reset_lock");
    for (int i = 0; i < 105; i++) begin
      rel        = int'(cyc + 1) - int'(r + 5);
      strobe_now = (rel >= 0) && (rel % 16 == 0) && (rel / 16 <= 6);
      rx_stb_in  = {strobe_now && (rel / 16 != 5), strobe_now};
      tick(1);
    end
    rx_stb_in = 2'b00;

    // Asynchronous reset while ONLINE and locked, then RX delay after release.
    c = cyc;
    rst_wr_n  = 1'b0;
    tx_online = 1'b0;
    expect_all_zero(c, "async_rst");
    tick(2);
    rst_wr_n = 1'b1;
    expect_at(c + 3, S_RXOD,  0, "post_rst_rx_load");
    expect_at(c + 4, S_RXOD,  0, "post_rst_rx_count");
    expect_at(c + 5, S_RXOD,  1, "post_rst_rx_online");
    expect_at(c + 5, S_STATE, 0, "post_rst_idle");
    tick(5);

    finishing = 1'b1;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
